oram: RTL and testbench
=======================

Name: oram

Overview:
- Result-side counterpart to the input RAM feeding `net`. It is the consumer of `net_out_0`, `net_out_1` and `net_rdy`.
- Captures one result pair per completed inference and classifies it (signed argmax over 2 outputs).
- Buffers results in a small FIFO and drains them to a downstream reader over a valid/ready handshake.
- Issues a one-cycle request for the next input sample once a result has been safely stored.

Parameters:
- DATA_W, 32, width of each net output word (matches `WordDataBus`).
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- net_out_0  input  DATA_W  net output 0, signed two's complement.
- net_out_1  input  DATA_W  net output 1, signed two's complement.
- net_rdy  input  1  level from `net`: high while outputs are valid, low between samples.
- rd_valid  output  1  head entry available.
- rd_ready  input  1  reader accepts head entry.
- rd_out_0  output  DATA_W  head entry, output 0.
- rd_out_1  output  DATA_W  head entry, output 1.
- rd_class  output  1  head entry class.
- fill  output  PTR_W+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky; a result was dropped.
- drop_cnt  output  8  dropped-result count, saturates at 255.
- next_req  output  1  one-cycle pulse requesting the next input sample.

Behaviour:
- Reset: when reset=0 at a clock edge, the following are cleared on that edge:
  - rd_valid=0, fill=0, overflow=0, drop_cnt=0, next_req=0.
  - Read/write pointers=0, rd_out_*=0, rd_class=0.
  - net_rdy edge register=0.
  - Reset takes priority over every other event. A result in flight is discarded and no next_req is issued.
- Capture: the capture event is `cap = net_rdy & ~net_rdy_q`, where `net_rdy_q` is net_rdy registered one cycle.
  - Exactly one capture per net_rdy high period, whatever its length.
  - A net_rdy already high when reset releases does not capture; net_rdy_q is loaded from net_rdy in the first cycle after reset.
- Classification: rd_class = ($signed(net_out_1) > $signed(net_out_0)). A tie gives 0.
  - Computed combinationally from the inputs in the cap cycle and stored with the entry.
- Stored entry: {class, out_0, out_1}, 2*DATA_W+1 bits.
- Write: on cap, the entry is written at wr_ptr and wr_ptr increments mod DEPTH when either holds:
  - fill<DEPTH, or
  - fill==DEPTH and a pop occurs in the same cycle (full with simultaneous pop: the write is accepted).
- Drop: on cap with fill==DEPTH and no pop, the entry is dropped.
  - overflow<=1; drop_cnt increments, saturating at 255.
  - Pointers and fill are unchanged.
- Pop: `pop = rd_valid & rd_ready`; on pop, rd_ptr increments mod DEPTH.
  - rd_ready while empty has no effect.
- fill: +1 on an accepted write without pop; -1 on pop without write; unchanged on both or neither.
- Read outputs: rd_valid = (fill!=0).
  - rd_out_0, rd_out_1 and rd_class are combinational from the head entry (show-ahead).
  - They hold stable while rd_valid=1 and rd_ready=0.
- Latency:
  - cap at edge N makes the entry visible with rd_valid=1 after edge N when the FIFO was empty.
  - next_req is high during the cycle following edge N.
- next_req: pulses for exactly one cycle after an accepted write when the post-write fill<DEPTH.
  - After a write that makes the FIFO full, no next_req is issued then. Instead, next_req pulses one cycle after the first pop that brings fill below DEPTH; this deferred request is held as a pending flag.
  - A dropped capture issues no next_req.
- Pointer wrap: natural mod-DEPTH wrap; full and empty are distinguished by fill, not by the pointers.
- overflow and drop_cnt are cleared only by reset.

Test Plan:
- Basic capture: out0=5, out1=-3 (0xFFFFFFFD), net_rdy held high for 4 cycles, then rd_ready=1 → single entry; rd_class=0; rd_out_1=0xFFFFFFFD; next_req pulses once; fill returns 1→0.
- Classify signed and tie:
  - out0=0x80000000, out1=0 → class=1.
  - out0=7, out1=7 → class=0.
- Fill to full with rd_ready=0: 8 captures, then a 9th → fill=8; next_req absent after the 8th; overflow=1; drop_cnt=1. Then one pop → next_req pulses; entries read in FIFO order 1..8.
- Full with simultaneous pop and capture → fill stays 8; overflow stays 0; new entry appears last; ordering intact across pointer wrap.
- Backpressure: rd_valid=1 with rd_ready=0 for 10 cycles → outputs stable; then a 1-cycle rd_ready pops exactly one entry.
- Reset mid-operation: fill=3 and overflow=1, reset=0 asserted for 1 cycle while net_rdy=1 → all outputs return to 0; no capture while net_rdy remains high; the next net_rdy rising edge captures normally.

Source files
------------

// File: rtl/oram.sv
// Result buffer behind `net`: classifies each completed inference, queues it in a show-ahead FIFO
// and drains it over valid/ready; next_req asks for a new sample once a result is safely stored.
module oram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] net_out_0,
   input  logic [DATA_W-1:0] net_out_1,
   input  logic              net_rdy,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_out_0,
   output logic [DATA_W-1:0] rd_out_1,
   output logic              rd_class,
   output logic [PTR_W:0]    fill,
   output logic              overflow,
   output logic [7:0]        drop_cnt,
   output logic              next_req
);

   localparam int ENT_W = 2 * DATA_W + 1;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   FILL_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    fill_q, fill_d;
   logic              net_rdy_q;
   logic              armed_q;
   logic              pend_q, pend_d;
   logic              next_req_q, next_req_d;
   logic              overflow_q;
   logic [7:0]        drop_cnt_q;

   logic              cap, pop, full, wr_ok, drop, cls;
   logic [ENT_W-1:0]  head;

   // armed_q masks the first cycle after reset so a level already high is not seen as an edge
   assign cap  = net_rdy & ~net_rdy_q & armed_q;
   assign pop  = rd_valid & rd_ready;
   assign full = (fill_q == FULL_CNT);
   assign wr_ok = cap & (~full | pop);
   assign drop  = cap & full & ~pop;
   assign cls   = ($signed(net_out_1) > $signed(net_out_0));

   always_comb begin
      fill_d = fill_q;
      if (wr_ok && !pop) begin
         fill_d = fill_q + FILL_ONE;
      end else if (!wr_ok && pop) begin
         fill_d = fill_q - FILL_ONE;
      end
   end

   // A write that fills the FIFO defers its request until a pop frees a slot
   always_comb begin
      pend_d     = (pend_q | wr_ok) & (fill_d == FULL_CNT);
      next_req_d = (pend_q | wr_ok) & (fill_d != FULL_CNT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         net_rdy_q  <= 1'b0;
         armed_q    <= 1'b0;
         pend_q     <= 1'b0;
         next_req_q <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         armed_q    <= 1'b1;
         net_rdy_q  <= net_rdy;
         fill_q     <= fill_d;
         pend_q     <= pend_d;
         next_req_q <= next_req_d;
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_q <= drop_cnt_q + 8'd1;
            end
         end
      end
   end

   // Storage is cleared on reset so the show-ahead outputs read zero while empty
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[wr_ptr_q] <= {cls, net_out_0, net_out_1};
      end
   end

   assign head     = mem_q[rd_ptr_q];
   assign rd_class = head[ENT_W-1];
   assign rd_out_0 = head[2*DATA_W-1:DATA_W];
   assign rd_out_1 = head[DATA_W-1:0];
   assign rd_valid = (fill_q != '0);
   assign fill     = fill_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;
   assign next_req = next_req_q;

endmodule

// File: tb/tb_oram.sv
// Directed bench for oram: capture, signed classification, full/drop, full-with-pop, backpressure, reset.
module tb_oram;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] net_out_0, net_out_1;
   logic        net_rdy, rd_ready;
   logic        rd_valid, rd_class, overflow, next_req;
   logic [31:0] rd_out_0, rd_out_1;
   logic [3:0]  fill;
   logic [7:0]  drop_cnt;

   int checks   = 0;
   int failures = 0;
   int nreq_cnt = 0;

   oram #(.DATA_W(32), .DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .reset(reset),
      .net_out_0(net_out_0), .net_out_1(net_out_1), .net_rdy(net_rdy),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_out_0(rd_out_0), .rd_out_1(rd_out_1), .rd_class(rd_class),
      .fill(fill), .overflow(overflow), .drop_cnt(drop_cnt), .next_req(next_req)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (next_req) nreq_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [31:0] o0, input logic [31:0] o1, input int hold);
      net_out_0 = o0;
      net_out_1 = o1;
      net_rdy   = 1'b1;
      repeat (hold) step();
      net_rdy = 1'b0;
      step();
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; net_rdy = 1'b0; rd_ready = 1'b0;
      net_out_0 = '0; net_out_1 = '0;
      step();
      do_reset();

      @(negedge clk);
      check("rst_valid", rd_valid, 0);
      check("rst_fill", fill, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_nreq", next_req, 0);
      check("rst_out0", rd_out_0, 0);
      check("rst_class", rd_class, 0);

      // basic capture with a long net_rdy high period
      step();
      nreq_cnt = 0;
      capture(32'd5, 32'hFFFF_FFFD, 4);
      @(negedge clk);
      check("basic_fill", fill, 1);
      check("basic_valid", rd_valid, 1);
      check("basic_out0", rd_out_0, 32'd5);
      check("basic_out1", rd_out_1, 32'hFFFF_FFFD);
      check("basic_class", rd_class, 0);
      check("basic_nreq", nreq_cnt, 1);
      pop_one();
      @(negedge clk);
      check("basic_empty", fill, 0);

      // signed compare and tie
      capture(32'h8000_0000, 32'd0, 1);
      @(negedge clk);
      check("cls_signed", rd_class, 1);
      pop_one();
      capture(32'd7, 32'd7, 1);
      @(negedge clk);
      check("cls_tie", rd_class, 0);
      pop_one();

      // fill to full, then drop a ninth result
      nreq_cnt = 0;
      for (int i = 1; i <= 8; i++) capture(i, 32'd100 + i, 1);
      @(negedge clk);
      check("full_fill", fill, 8);
      check("full_nreq", nreq_cnt, 7);
      capture(32'd99, 32'd99, 2);
      @(negedge clk);
      check("drop_fill", fill, 8);
      check("drop_ovf", overflow, 1);
      check("drop_cnt", drop_cnt, 1);
      check("drop_nreq", nreq_cnt, 7);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("order_out0", rd_out_0, i);
         pop_one();
      end
      @(negedge clk);
      check("order_nreq", nreq_cnt, 8);
      check("order_empty", fill, 0);

      // full with simultaneous pop and capture
      do_reset();
      nreq_cnt = 0;
      for (int i = 11; i <= 18; i++) capture(i, 32'd200 + i, 1);
      net_out_0 = 32'd19; net_out_1 = 32'd219;
      net_rdy = 1'b1; rd_ready = 1'b1;
      step();
      net_rdy = 1'b0; rd_ready = 1'b0;
      step();
      @(negedge clk);
      check("fp_fill", fill, 8);
      check("fp_ovf", overflow, 0);
      check("fp_nreq", nreq_cnt, 7);
      for (int i = 12; i <= 19; i++) begin
         @(negedge clk);
         check("fp_out0", rd_out_0, i);
         check("fp_out1", rd_out_1, 32'd200 + i);
         pop_one();
      end
      @(negedge clk);
      check("fp_empty", fill, 0);
      check("fp_nreq_end", nreq_cnt, 8);

      // backpressure holds head stable
      capture(32'h55, 32'h66, 1);
      capture(32'h77, 32'h11, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_hold", {rd_valid, rd_class, rd_out_0}, {2'b11, 32'h55});
         step();
      end
      pop_one();
      @(negedge clk);
      check("bp_fill", fill, 1);
      check("bp_head", rd_out_0, 32'h77);
      pop_one();

      // reset in mid-operation while net_rdy is high
      for (int i = 1; i <= 9; i++) capture(32'd300 + i, 32'd0, 1);
      repeat (5) pop_one();
      @(negedge clk);
      check("pre_fill", fill, 3);
      check("pre_ovf", overflow, 1);
      step();
      net_out_0 = 32'd500; net_out_1 = 32'd600;
      reset = 1'b0; net_rdy = 1'b1;
      step();
      reset = 1'b1;
      nreq_cnt = 0;
      repeat (3) step();
      @(negedge clk);
      check("mid_fill", fill, 0);
      check("mid_valid", rd_valid, 0);
      check("mid_ovf", overflow, 0);
      check("mid_drop", drop_cnt, 0);
      check("mid_out0", rd_out_0, 0);
      check("mid_nreq", nreq_cnt, 0);
      net_rdy = 1'b0;
      step();
      capture(32'h42, 32'h43, 1);
      @(negedge clk);
      check("post_fill", fill, 1);
      check("post_out0", rd_out_0, 32'h42);
      check("post_class", rd_class, 1);
      check("post_nreq", nreq_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
